// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port word-addressed data memory.
// Latency: gnt 1 cycle after req is sampled in IDLE, rvalid 3 cycles after; one access in flight.
// Backpressure: requesters hold req until gnt; requests outside IDLE simply wait.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

    state_t            state;
    logic              last_port;
    logic              win_q;
    logic              we_q;
    logic              inv_q;
    logic              en_q;
    logic              mwe_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [DATA_W-1:0] mwdata_q;

    logic              win;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_inv;

    always_comb begin
        win       = (req0 & req1) ? ~last_port : req1;
        sel_we    = win ? we1 : we0;
        sel_addr  = win ? addr1 : addr0;
        sel_wdata = win ? wdata1 : wdata0;
        sel_inv   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
    end

    // Reset gates the strobe combinationally so a store caught in ISSUE never writes.
    assign mem_en    = en_q & ~reset;
    assign mem_we    = mem_en & mwe_q;
    assign mem_addr  = mem_en ? maddr_q : '0;
    assign mem_wdata = mem_en ? mwdata_q : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_port <= 1'b1;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            inv_q     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            en_q      <= 1'b0;
            mwe_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
        end else begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            en_q     <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        win_q     <= win;
                        last_port <= win;
                        we_q      <= sel_we;
                        inv_q     <= sel_inv;
                        gnt0      <= ~win;
                        gnt1      <= win;
                        if (!sel_inv) begin
                            en_q     <= 1'b1;
                            mwe_q    <= sel_we;
                            maddr_q  <= sel_addr[ADDR_W+1:2];
                            mwdata_q <= sel_wdata;
                        end
                        // Store errors report with the grant; load errors wait for rvalid.
                        if (sel_we) begin
                            err0 <= ~win & sel_inv;
                            err1 <= win & sel_inv;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= we_q ? IDLE : RDWAIT;
                end
                RDWAIT: begin
                    if (win_q) begin
                        rdata1  <= inv_q ? '0 : mem_rdata;
                        rvalid1 <= 1'b1;
                        err1    <= inv_q;
                    end else begin
                        rdata0  <= inv_q ? '0 : mem_rdata;
                        rvalid0 <= 1'b1;
                        err0    <= inv_q;
                    end
                    state <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the single-port, word-addressed data memory. It shares the memory between port 0 (core load/store unit) and port 1 (debug/program loader). It registers each winning request, drives one memory access, and returns read data with a valid pulse. It also flags misaligned or out-of-range addresses instead of accessing memory.

Parameters:
ADDR_W, 10, memory word-address width (2^ADDR_W words; byte address bits [ADDR_W+1:2] index the memory).
DATA_W, 32, data width.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req0 / req1  input  1  access request from port 0 / port 1; held with its fields stable until that port's gnt.
we0 / we1  input  1  1 = store, 0 = load.
addr0 / addr1  input  32  byte address.
wdata0 / wdata1  input  DATA_W  store data.
gnt0 / gnt1  output  1  one-cycle pulse: request accepted; requester may drop or change req the next cycle.
rvalid0 / rvalid1  output  1  one-cycle pulse: rdata/err valid for the completed load.
rdata0 / rdata1  output  DATA_W  load result; holds its value until the next rvalid on that port.
err0 / err1  output  1  pulses with gnt (stores) or rvalid (loads) when the address is invalid.
mem_en  output  1  memory access strobe.
mem_we  output  1  memory write enable; meaningful only when mem_en=1.
mem_addr  output  ADDR_W  word index.
mem_wdata  output  DATA_W  write data.
mem_rdata  input  DATA_W  read data, valid exactly 1 cycle after a read strobe.

Behaviour:
- Reset: state=IDLE, last-served pointer=1 (port 0 wins the first tie). All outputs are 0: gnt*, rvalid*, err*, rdata*, mem_*.
- States: IDLE, ISSUE, RDWAIT, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, any req:
  - Pick the winner: the only requester, or on a tie the port not equal to the pointer.
  - Latch we, addr, wdata and the winner id; set pointer=winner.
  - Go to ISSUE.
  - A requester is never granted twice while its req is held continuously before its gnt.
- Address is invalid if addr[1:0]!=0 or addr[31:ADDR_W+2]!=0.
- ISSUE (1 cycle):
  - Assert gnt for the winner.
  - If the address is valid: mem_en=1, mem_we=latched we, mem_addr=addr[ADDR_W+1:2], mem_wdata=latched wdata.
  - If the address is invalid: mem_en=0.
  - Store: err=invalid in the same cycle; next state IDLE.
  - Load: next state RDWAIT.
- RDWAIT (1 cycle): if the address was valid, capture mem_rdata into the winner's rdata register; if invalid, load 0. Go to RESP.
- RESP (1 cycle): assert the winner's rvalid; err=invalid. Go to IDLE.
- Latency from req sampled in IDLE (cycle N):
  - gnt at N+1; the memory write takes effect at the end of N+1.
  - rvalid at N+3.
  - Next arbitration: at N+2 after a store, N+4 after a load.
- The non-winning port's rdata is never modified.
- Requests arriving outside IDLE wait; arbitration happens only in IDLE.
- A request dropped before gnt is legal and is simply not served.
- At most one gnt, one rvalid and one mem_en per cycle; a gnt never coincides with an rvalid on the same port.
- mem_* outputs are 0 whenever mem_en=0 (no stale address or data is driven).
- Reset asserted in any state:
  - Next cycle is IDLE with all outputs 0.
  - A pending load produces no rvalid.
  - A store in ISSUE during reset does not write (mem_en forced 0).
- Address wrap: max valid byte address 0x00000FFC (ADDR_W=10) maps to index 1023; 0x00001000 is invalid.

Test Plan:
1. Reset, then req0 store addr=0x10 wdata=0xDEADBEEF -> gnt0 at N+1 with mem_en=1, mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF; err0=0; idle at N+2.
2. req0 load addr=0x10 after test 1, memory model returns 0xDEADBEEF -> gnt0 at N+1, mem_en=1, mem_we=0; rvalid0 at N+3 with rdata0=0xDEADBEEF; rdata1 unchanged.
3. req0 and req1 both held as loads from reset -> grant order 0,1,0,1 with gnt spacing of 4 cycles; each rvalid goes to the port matching its prior gnt.
4. req1 store addr=0x12 (misaligned), then req1 load addr=0x1000 (out of range) -> mem_en stays 0 throughout; err1 pulses with gnt1 for the store; the load gives rvalid1 with err1=1 and rdata1=0.
5. req0 load granted; reset asserted during RDWAIT -> no rvalid0; all outputs 0 the next cycle; a subsequent tie grants port 0 first.
6. req1 store to 0xFFC, then load 0xFFC -> mem_addr=1023 for both; rvalid1 returns the stored value.
